// File: rtl/aes_result_merger_if.sv
// rtl/aes_result_merger_if.sv - job control, lane input streams and packed output stream of the AES result merger
interface aes_result_merger_if #(
  parameter int ENGINE_NUM = 4
);
  logic                      job_start;
  logic [31:0]               beat_num;
  logic                      job_done;
  logic                      busy;
  logic [128*ENGINE_NUM-1:0] s_tdata;
  logic [ENGINE_NUM-1:0]     s_tvalid;
  logic [ENGINE_NUM-1:0]     s_tready;
  logic [128*ENGINE_NUM-1:0] m_tdata;
  logic                      m_tvalid;
  logic                      m_tready;
  logic                      m_tlast;

  modport master (
    output job_start, beat_num, s_tdata, s_tvalid, m_tready,
    input  job_done, busy, s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  job_start, beat_num, s_tdata, s_tvalid, m_tready,
    output job_done, busy, s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/aes_result_merger.sv
// rtl/aes_result_merger.sv - collects one 128-bit block per AES engine lane and emits them as one packed beat per job step
module aes_result_merger #(
  parameter int ENGINE_NUM = 4
) (
  input logic              CLK,
  input logic              RESETn,
  aes_result_merger_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic                      start_job;
  logic                      done_nxt;
  logic [31:0]               beat_num_r;
  logic [31:0]               pack_cnt;
  logic [ENGINE_NUM-1:0]     lane_full;
  logic [ENGINE_NUM-1:0]     lane_hs;
  logic [127:0]              hold [ENGINE_NUM];
  logic [128*ENGINE_NUM-1:0] hold_flat;
  logic                      lanes_open;
  logic                      pack;
  logic                      out_hs;
  logic [128*ENGINE_NUM-1:0] m_tdata_r;
  logic                      m_tvalid_r;
  logic                      m_tlast_r;
  logic                      job_done_r;

  // Lane readiness depends only on registers so upstream engines see no combinational path from their own valid.
  assign lanes_open   = (state == RUN) && (pack_cnt < beat_num_r);
  assign bus.s_tready = {ENGINE_NUM{lanes_open}} & ~lane_full;
  assign lane_hs      = bus.s_tvalid & bus.s_tready;
  assign out_hs       = m_tvalid_r && bus.m_tready;
  assign pack         = (state == RUN) && (&lane_full) && (!m_tvalid_r || bus.m_tready);

  assign bus.m_tdata  = m_tdata_r;
  assign bus.m_tvalid = m_tvalid_r;
  assign bus.m_tlast  = m_tlast_r;
  assign bus.job_done = job_done_r;
  assign bus.busy     = (state == RUN);

  always_comb begin
    hold_flat = '0;
    for (int i = 0; i < ENGINE_NUM; i++) begin
      hold_flat[128*i +: 128] = hold[i];
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_job = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.job_start) begin
          if (bus.beat_num != 32'd0) begin
            state_nxt = RUN;
            start_job = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_hs && m_tlast_r) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      beat_num_r <= '0;
      pack_cnt   <= '0;
      lane_full  <= '0;
      m_tdata_r  <= '0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      job_done_r <= 1'b0;
      for (int i = 0; i < ENGINE_NUM; i++) begin
        hold[i] <= '0;
      end
    end else begin
      job_done_r <= done_nxt;

      if (start_job) begin
        beat_num_r <= bus.beat_num;
        pack_cnt   <= '0;
      end else if (pack) begin
        pack_cnt <= pack_cnt + 32'd1;
      end

      for (int i = 0; i < ENGINE_NUM; i++) begin
        if (lane_hs[i]) begin
          hold[i] <= bus.s_tdata[128*i +: 128];
        end
      end

      // A full lane is never ready, so a pack and a capture never collide on the same lane.
      if (start_job || pack) begin
        lane_full <= '0;
      end else begin
        lane_full <= lane_full | lane_hs;
      end

      if (pack) begin
        m_tdata_r  <= hold_flat;
        m_tvalid_r <= 1'b1;
        m_tlast_r  <= (pack_cnt == beat_num_r - 32'd1);
      end else if (out_hs) begin
        m_tvalid_r <= 1'b0;
        m_tlast_r  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_result_merger.sv
// tb/tb_aes_result_merger.sv - randomized scoreboard bench for aes_result_merger
module tb_aes_result_merger;
  localparam int NE   = 4;
  localparam int MAXB = 100;
  localparam int W    = 128 * NE;

  logic CLK;
  logic RESETn;

  aes_result_merger_if #(.ENGINE_NUM(NE)) bif ();

  aes_result_merger #(.ENGINE_NUM(NE)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [127:0] lane_data [NE][MAXB];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: beat order/content, output stability under stall, job_done timing.
  logic         done_exp_next = 1'b0;
  logic         done_exp_now;
  logic         stall_v = 1'b0;
  logic [W-1:0] stall_data;
  logic         stall_last;
  logic [W-1:0] e_data;
  logic         e_last;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RESETn) begin
        exp_q.delete();
        exp_last_q.delete();
        done_exp_next = 1'b0;
        stall_v = 1'b0;
      end else begin
        done_exp_now = done_exp_next;
        if (bif.job_done || done_exp_now) chk("job_done", W'(bif.job_done), W'(done_exp_now));
        if (bif.job_done) done_cnt++;
        if (stall_v) begin
          chk("m_tvalid_held", W'(bif.m_tvalid), W'(1));
          chk("m_tdata_stable", bif.m_tdata, stall_data);
          chk("m_tlast_stable", W'(bif.m_tlast), W'(stall_last));
        end
        if (bif.m_tvalid && bif.m_tready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", W'(1), W'(0));
          end else begin
            e_data = exp_q.pop_front();
            e_last = exp_last_q.pop_front();
            chk("beat_data", bif.m_tdata, e_data);
            chk("beat_last", W'(bif.m_tlast), W'(e_last));
          end
        end
        stall_v    = bif.m_tvalid && !bif.m_tready;
        stall_data = bif.m_tdata;
        stall_last = bif.m_tlast;
        done_exp_next = (bif.m_tvalid && bif.m_tready && bif.m_tlast) ||
                        (bif.job_start && bif.beat_num == 32'd0 && !bif.busy);
      end
    end
  end

  // data_mode 0: lane i sends value i+1; 1: random. delay_mode 0: none, 1: lane 3 first/lane 0 last, 2: random.
  // rdy_mode 0: always ready, 1: random, 2: held low for 20 cycles.
  task automatic run_job(input int n, input int data_mode, input int delay_mode, input int rdy_mode);
    int idx[NE];
    int wait_c[NE];
    int cyc;
    int done_before;
    logic [NE-1:0] hs;
    logic [W-1:0] beat;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NE; i++) begin
        lane_data[i][k] = (data_mode == 0) ? 128'(i + 1) : {$urandom, $urandom, $urandom, $urandom};
        beat[128*i +: 128] = lane_data[i][k];
      end
      exp_q.push_back(beat);
      exp_last_q.push_back(k == n - 1);
    end
    done_before = done_cnt;
    bif.job_start = 1'b1;
    bif.beat_num  = 32'(n);
    @(posedge CLK); #1;
    bif.job_start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      idx[i] = 0;
      wait_c[i] = (delay_mode == 1) ? (NE - 1 - i) * 2 : (delay_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end
    cyc = 0;
    while (done_cnt == done_before && cyc < 20000) begin
      for (int i = 0; i < NE; i++) begin
        if (!bif.s_tvalid[i] && idx[i] < n) begin
          if (wait_c[i] == 0) begin
            bif.s_tvalid[i] = 1'b1;
            bif.s_tdata[128*i +: 128] = lane_data[i][idx[i]];
          end else begin
            wait_c[i]--;
          end
        end
      end
      bif.m_tready  = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= 20);
      bif.job_start = (delay_mode == 2 && cyc == 30);
      bif.beat_num  = 32'd5;
      @(negedge CLK);
      hs = bif.s_tvalid & bif.s_tready;
      if (rdy_mode == 2 && cyc == 19) begin
        chk("stall_s_tready", W'(bif.s_tready), W'(0));
        chk("stall_m_tvalid", W'(bif.m_tvalid), W'(1));
      end
      @(posedge CLK); #1;
      bif.job_start = 1'b0;
      for (int i = 0; i < NE; i++) begin
        if (hs[i]) begin
          idx[i]++;
          bif.s_tvalid[i] = 1'b0;
          wait_c[i] = (delay_mode == 1) ? (NE - 1 - i) * 2 : (delay_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        end
      end
      cyc++;
    end
    if (done_cnt == done_before) chk("job_timeout", W'(0), W'(1));
    bif.s_tvalid = '0;
    bif.m_tready = 1'b1;
    chk("queue_empty", W'(exp_q.size()), W'(0));
    chk("busy_after_job", W'(bif.busy), W'(0));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_tvalid"}, W'(bif.m_tvalid), W'(0));
    chk({tag, "_m_tlast"}, W'(bif.m_tlast), W'(0));
    chk({tag, "_m_tdata"}, bif.m_tdata, W'(0));
    chk({tag, "_s_tready"}, W'(bif.s_tready), W'(0));
    chk({tag, "_busy"}, W'(bif.busy), W'(0));
    chk({tag, "_job_done"}, W'(bif.job_done), W'(0));
  endtask

  int done_before;

  initial begin
    RESETn        = 1'b0;
    bif.job_start = 1'b0;
    bif.beat_num  = '0;
    bif.s_tdata   = '0;
    bif.s_tvalid  = '0;
    bif.m_tready  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    RESETn = 1'b1;

    run_job(1, 0, 0, 0);
    chk("single_beat_value", bif.m_tdata, {128'd4, 128'd3, 128'd2, 128'd1});
    run_job(3, 1, 1, 0);
    run_job(2, 1, 0, 2);

    done_before   = done_cnt;
    bif.job_start = 1'b1;
    bif.beat_num  = 32'd0;
    @(posedge CLK); #1;
    bif.job_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      chk("zero_job_busy", W'(bif.busy), W'(0));
      chk("zero_job_m_tvalid", W'(bif.m_tvalid), W'(0));
    end
    chk("zero_job_done_count", W'(done_cnt), W'(done_before + 1));

    @(posedge CLK); #1;
    bif.job_start = 1'b1;
    bif.beat_num  = 32'd2;
    bif.s_tdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bif.s_tvalid  = 4'b0011;
    @(posedge CLK); #1;
    bif.job_start = 1'b0;
    @(posedge CLK); #1;
    bif.s_tvalid = '0;
    @(negedge CLK); #1;
    chk("abort_busy", W'(bif.busy), W'(1));
    chk("abort_s_tready", W'(bif.s_tready), W'(4'b1100));
    #1 RESETn = 1'b0;
    #1;
    chk_zero_outputs("abort");
    @(posedge CLK); #1;
    RESETn = 1'b1;
    run_job(1, 1, 0, 0);

    run_job(MAXB, 1, 2, 1);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
